// File: rtl/sobel_window_gen_pkg.sv
// Shared constants for the Sobel window front end and the sobel3x3det bench.
// Window slots are numbered row-major: Z1..Z3 top row, Z4..Z6 centre row
// (Z5 is the centre pixel), Z7..Z9 bottom row.
package sobel_window_gen_pkg;

  localparam int unsigned SOBEL_PIX_W = 8;
  localparam int unsigned WIN_SIZE    = 9;

  localparam int unsigned Z1 = 0;
  localparam int unsigned Z2 = 1;
  localparam int unsigned Z3 = 2;
  localparam int unsigned Z4 = 3;
  localparam int unsigned Z5 = 4;
  localparam int unsigned Z6 = 5;
  localparam int unsigned Z7 = 6;
  localparam int unsigned Z8 = 7;
  localparam int unsigned Z9 = 8;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixel storage, 1 read / 1 write port on a shared address.
// The read is combinational and returns the value stored before any write at
// the same address on this clock edge (read-before-write).
//   clk   : clock
//   we    : write enable
//   addr  : column index
//   wdata : pixel to store at addr
//   rdata : pixel currently stored at addr
module sobel_line_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIX_W-1:0]         wdata,
  output logic [PIX_W-1:0]         rdata
);

  // Contents need no reset: rows are fully rewritten before they are used.
  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator feeding the sobel3x3det detector.
// Takes a raster-order pixel stream and emits one 3x3 neighbourhood per
// interior pixel, with valid/ready handshakes on both sides.
//   clk        : clock
//   reset      : asynchronous active-low reset
//   pix_in     : input pixel
//   pix_valid  : pix_in valid
//   pix_ready  : block can accept a pixel this cycle
//   z1..z9     : window, row-major, z5 is the centre pixel
//   win_valid  : z1..z9 hold a valid window
//   win_ready  : downstream takes the window this cycle
//   win_eol    : window is the last of its row
//   win_last   : window is the last of the frame
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int unsigned IMG_ROWS = 3,
  parameter int unsigned IMG_COLS = 4,
  parameter int unsigned PIX_W    = SOBEL_PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] z1,
  output logic [PIX_W-1:0] z2,
  output logic [PIX_W-1:0] z3,
  output logic [PIX_W-1:0] z4,
  output logic [PIX_W-1:0] z5,
  output logic [PIX_W-1:0] z6,
  output logic [PIX_W-1:0] z7,
  output logic [PIX_W-1:0] z8,
  output logic [PIX_W-1:0] z9,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             win_eol,
  output logic             win_last
);

  localparam int unsigned CW = $clog2(IMG_COLS);
  localparam int unsigned RW = $clog2(IMG_ROWS);
  localparam logic [CW-1:0] ColLast = CW'(IMG_COLS - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_ROWS - 1);
  localparam logic [CW-1:0] ColTwo  = CW'(2);
  localparam logic [RW-1:0] RowTwo  = RW'(2);

  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic             accept;
  logic             emit;
  logic             at_eol;
  logic             at_eof;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;
  logic [PIX_W-1:0] win_q [WIN_SIZE];
  logic [PIX_W-1:0] win_d [WIN_SIZE];
  logic [PIX_W-1:0] z_q   [WIN_SIZE];
  logic             win_valid_q;
  logic             eol_q;
  logic             last_q;

  // Single output register stage: a new pixel may enter whenever the held
  // window is empty or leaves this cycle.
  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign at_eol    = (col_q == ColLast);
  assign at_eof    = at_eol && (row_q == RowLast);
  // Requiring row >= 2 of the current frame keeps stale line data out.
  assign emit      = accept && (row_q >= RowTwo) && (col_q >= ColTwo);

  // lb0 holds row r-1, lb1 holds row r-2; lb1 is refilled from lb0's old word.
  sobel_line_buffer #(
    .DEPTH (IMG_COLS),
    .PIX_W (PIX_W)
  ) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (pix_in),
    .rdata (lb0_rd)
  );

  sobel_line_buffer #(
    .DEPTH (IMG_COLS),
    .PIX_W (PIX_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Window after this accept: shift columns left, new right column enters.
  always_comb begin
    win_d[Z1] = win_q[Z2];
    win_d[Z2] = win_q[Z3];
    win_d[Z3] = lb1_rd;
    win_d[Z4] = win_q[Z5];
    win_d[Z5] = win_q[Z6];
    win_d[Z6] = lb0_rd;
    win_d[Z7] = win_q[Z8];
    win_d[Z8] = win_q[Z9];
    win_d[Z9] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= win_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      eol_q       <= 1'b0;
      last_q      <= 1'b0;
      z_q         <= '{default: '0};
    end else begin
      if (accept) begin
        if (at_eol) begin
          col_q <= '0;
          row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (emit) begin
        z_q         <= win_d;
        win_valid_q <= 1'b1;
        eol_q       <= at_eol;
        last_q      <= at_eof;
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  assign z1        = z_q[Z1];
  assign z2        = z_q[Z2];
  assign z3        = z_q[Z3];
  assign z4        = z_q[Z4];
  assign z5        = z_q[Z5];
  assign z6        = z_q[Z6];
  assign z7        = z_q[Z7];
  assign z8        = z_q[Z8];
  assign z9        = z_q[Z9];
  assign win_valid = win_valid_q;
  assign win_eol   = eol_q;
  assign win_last  = last_q;

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Streaming front end for the combinational 3x3 Sobel detector.
- Accepts a raster-order pixel stream (row-major, one frame of IMG_ROWS x IMG_COLS) and emits one 3x3 neighbourhood per interior pixel on z1..z9, with valid/ready flow control.
- Replaces the bench-side nested-loop window extraction with synthesizable line buffering.
- Sits between the pixel source and sobel3x3det; its z1..z9 outputs connect directly to the detector inputs.

Parameters:
- IMG_ROWS, 3, frame height in pixels; must be >= 3.
- IMG_COLS, 4, frame width in pixels; must be >= 3.
- PIX_W, 8, pixel width in bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pix_in  in  PIX_W  input pixel.
- pix_valid  in  1  pix_in is valid this cycle.
- pix_ready  out  1  block can accept a pixel this cycle.
- z1..z9  out  PIX_W each  window, row-major: z1..z3 row above centre, z4..z6 centre row (z5 is centre), z7..z9 row below.
- win_valid  out  1  z1..z9 hold a valid window.
- win_ready  in  1  downstream accepts the window this cycle.
- win_eol  out  1  current window is the last one of its row (centre column IMG_COLS-2).
- win_last  out  1  current window is the last one of the frame.

Behaviour:
- Reset (asynchronous, reset=0):
  - z1..z9 = 0; win_valid, win_eol and win_last = 0.
  - Row and column counters = 0.
  - Line-buffer contents are don't-care.
  - pix_ready = 1 as soon as reset releases.
- Reset asserted mid-frame aborts the frame. The next accepted pixel is (0,0) of a new frame.
- Accept rule: a pixel is accepted when pix_valid && pix_ready.
  - pix_ready = !win_valid || win_ready. This is combinational, with a single output register stage.
  - A window is consumed when win_valid && win_ready.
- Counters: col runs 0..IMG_COLS-1 and row runs 0..IMG_ROWS-1.
  - Both advance only on accept.
  - col wraps to 0 and row increments at end of line.
  - At the last pixel of a frame both wrap to 0. The next pixel starts a new frame with no gap or idle cycle.
- Line buffers: two rows, lb0 (row r-1) and lb1 (row r-2), each IMG_COLS deep, indexed by col.
  - On accepting pixel (r,c): lb1[c] <= lb0[c] and lb0[c] <= pix_in.
- Window shift register: 3x3 array.
  - On accept, columns shift left.
  - The new right column is {lb1[c], lb0[c], pix_in} (top, mid, bottom).
- Emission: when the accepted pixel has r >= 2 and c >= 2, the next clock edge loads z1..z9 from the updated window and sets win_valid = 1.
  - The window centre is (r-1, c-1).
  - z1 = pixel(r-2,c-2) ... z9 = pixel(r,c).
  - Latency is 1 cycle from accept to win_valid.
- win_eol = (c == IMG_COLS-1) and win_last = (win_eol && r == IMG_ROWS-1). Both are captured with the window.
- Accepts with r < 2 or c < 2 update the buffers only.
  - If win_valid is set and win_ready is high in the same cycle, win_valid clears.
- Simultaneous consume and emit: the new window loads and win_valid stays 1, giving a throughput of 1 window per clock.
- Backpressure: while win_valid && !win_ready:
  - z1..z9, win_eol and win_last are held stable.
  - pix_ready = 0, and no counter or buffer changes.
- Window count: exactly (IMG_ROWS-2)*(IMG_COLS-2) windows per frame, in raster order of centre pixel.
- Stale line-buffer data from a previous frame is never emitted, because emission requires r >= 2 on the current frame.

Decomposition:
- Shared constants header holds the PIX_W default and the window index order (Z1..Z9 mapping). The sobel3x3det bench and this block both use it.
- One sub-module: sobel_line_buffer, a 1-read/1-write row memory of IMG_COLS x PIX_W with read-before-write at the same address. It is instantiated twice (lb0, lb1).
- Counters, shift array, output register and handshake live in the top module.

Test Plan:
- Basic window extraction:
  - Stimulus: 3x4 frame, pixels 0x00..0x0B streamed with pix_valid=1 and win_ready=1.
  - Response: exactly 2 windows.
    - Window 1: z1..z9 = 00,01,02,04,05,06,08,09,0A.
    - Window 2: z1..z9 = 01,02,03,05,06,07,09,0A,0B.
  - Window 2 has win_eol=1 and win_last=1. The first window appears 1 cycle after pixel 0x0A is accepted.
- Backpressure:
  - Stimulus: same frame, with win_ready held 0 for 5 cycles after the first win_valid.
  - Response: z1..z9 are held at window 1 values, pix_ready=0, and pixel 0x0B is not consumed. Window 2 is correct after release.
- Back-to-back frames:
  - Stimulus: two 3x4 frames, the second with values 0x10..0x1B, no gaps.
  - Response: 4 windows. Frame-2 windows are 10,11,12,14,15,16,18,19,1A and 11,12,13,15,16,17,19,1A,1B, with no frame-1 data leaking.
- Reset mid-frame:
  - Stimulus: reset=0 asserted after 7 pixels, then released and a fresh 3x4 frame 0x20..0x2B sent.
  - Response: outputs are 0 during reset, and the windows match the fresh frame only (20,21,22,24,25,26,28,29,2A first).
- Larger parameters:
  - Stimulus: IMG_ROWS=5, IMG_COLS=5, pixel value = 5*r+c, with pix_valid randomly deasserted.
  - Response: 9 windows with centre z5 = 06,07,08,0B,0C,0D,10,11,12. win_eol is set on the 3rd, 6th and 9th windows; win_last is set on the 9th only.
